// File: rtl/aud_dsp_gen2.sv
// Audio clip player datapath: fetches stored samples from SRAM and paces them to a DAC player.
// Supports fast, zero-order-hold and linear-interpolation slow playback in either direction.
module aud_dsp_gen2 #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 20,
  parameter int SPEED_W = 4,
  parameter int RD_LAT  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_fast,
  input  logic              i_slow_0,
  input  logic              i_slow_1,
  input  logic              i_reverse,
  input  logic [SPEED_W-1:0] i_speed,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic              i_daclrck,
  input  logic [DATA_W-1:0] i_sram_data,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_dac_data,
  output logic              o_player_en,
  input  logic              i_player_ack,
  output logic              o_done
);

  localparam int CALC_W = DATA_W + SPEED_W + 1;
  localparam int LAT_W  = $clog2(RD_LAT + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CALC,
    S_WAIT_LRCK,
    S_PLAY,
    S_PAUSED
  } state_t;

  typedef enum logic [1:0] {
    M_NORM,
    M_FAST,
    M_ZOH,
    M_LIN
  } mode_t;

  state_t                    state, state_nx;
  mode_t                     mode_in, mode_lat, mode_sel;
  logic [SPEED_W-1:0]        spd_in, spd_lat, spd_sel, k;
  logic [ADDR_W-1:0]         addr, addr_nx;
  logic [ADDR_W:0]           step, addr_fwd, addr_rev;
  logic signed [DATA_W-1:0]  prev, dac, cur_p0, samp_p1;
  logic [LAT_W-1:0]          lat_cnt;
  logic                      rev, lrck_q, en, done, pause_pend;
  logic                      lrck_fall, span_end, clip_end, fetch_last;

  // prev + ((cur - prev) * k) / speed, truncating toward zero, then truncated to DATA_W
  function automatic logic signed [DATA_W-1:0] lin_interp(
    input logic signed [DATA_W-1:0] p,
    input logic signed [DATA_W-1:0] c,
    input logic [SPEED_W-1:0]       kk,
    input logic [SPEED_W-1:0]       sp
  );
    logic signed [CALC_W-1:0] px, cx, kx, sx, prod, sum;
    px   = $signed({{(SPEED_W+1){p[DATA_W-1]}}, p});
    cx   = $signed({{(SPEED_W+1){c[DATA_W-1]}}, c});
    kx   = $signed({{(DATA_W+1){1'b0}}, kk});
    sx   = $signed({{(DATA_W+1){1'b0}}, sp});
    prod = (cx - px) * kx;
    sum  = px + prod / sx;
    lin_interp = DATA_W'(sum);
  endfunction

  always_comb begin
    mode_in = M_NORM;
    if (i_fast)
      mode_in = M_FAST;
    else if (i_slow_1)
      mode_in = M_LIN;
    else if (i_slow_0)
      mode_in = M_ZOH;
  end

  assign spd_in   = (i_speed == '0) ? SPEED_W'(1) : i_speed;
  assign mode_sel = (k == '0) ? mode_in : mode_lat;
  assign spd_sel  = (k == '0) ? spd_in : spd_lat;

  assign lrck_fall  = lrck_q & ~i_daclrck;
  assign fetch_last = (lat_cnt == LAT_W'(RD_LAT));
  assign span_end   = (mode_lat == M_FAST) || (mode_lat == M_NORM) ||
                      (k == spd_lat - SPEED_W'(1));
  assign step       = (mode_lat == M_FAST) ? {{(ADDR_W+1-SPEED_W){1'b0}}, spd_lat}
                                           : (ADDR_W+1)'(1);
  assign addr_fwd   = {1'b0, addr} + step;
  assign addr_rev   = {1'b0, addr} - step;
  assign clip_end   = rev ? addr_rev[ADDR_W] : (addr_fwd > {1'b0, i_end_addr});
  assign addr_nx    = rev ? addr_rev[ADDR_W-1:0] : addr_fwd[ADDR_W-1:0];

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:      if (i_start && !i_pause) state_nx = S_FETCH;
      S_FETCH:     if (i_pause) state_nx = S_PAUSED;
                   else if (fetch_last) state_nx = S_CALC;
      S_CALC:      if (i_pause || pause_pend) state_nx = S_PAUSED;
                   else state_nx = S_WAIT_LRCK;
      S_WAIT_LRCK: if (i_pause) state_nx = S_PAUSED;
                   else if (lrck_fall) state_nx = S_PLAY;
      S_PLAY:      if (i_player_ack) begin
                     if (!span_end) state_nx = S_CALC;
                     else if (clip_end) state_nx = S_IDLE;
                     else state_nx = S_FETCH;
                   end
      S_PAUSED:    if (i_start && !i_pause) state_nx = S_FETCH;
      default:     state_nx = S_IDLE;
    endcase
    if (i_stop)
      state_nx = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      addr       <= '0;
      prev       <= '0;
      dac        <= '0;
      k          <= '0;
      rev        <= 1'b0;
      lrck_q     <= 1'b0;
      en         <= 1'b0;
      done       <= 1'b0;
      lat_cnt    <= '0;
      pause_pend <= 1'b0;
      mode_lat   <= M_NORM;
      spd_lat    <= SPEED_W'(1);
    end else begin
      state      <= state_nx;
      lrck_q     <= i_daclrck;
      done       <= 1'b0;
      lat_cnt    <= (state == S_FETCH) ? lat_cnt + LAT_W'(1) : '0;
      pause_pend <= (pause_pend || (state == S_PLAY && i_pause)) &&
                    !(state_nx == S_PAUSED || state_nx == S_IDLE);
      if (i_stop) begin
        addr <= rev ? i_end_addr : '0;
        en   <= 1'b0;
        dac  <= '0;
        prev <= '0;
        k    <= '0;
      end else begin
        unique case (state)
          S_IDLE: if (state_nx == S_FETCH) begin
            rev  <= i_reverse;
            addr <= i_reverse ? i_end_addr : '0;
            prev <= '0;
            k    <= '0;
          end
          S_CALC: if (k == '0) begin
            mode_lat <= mode_in;
            spd_lat  <= spd_in;
          end
          S_WAIT_LRCK: if (state_nx == S_PLAY) begin
            en  <= 1'b1;
            dac <= samp_p1;
          end
          S_PLAY: if (i_player_ack) begin
            en <= 1'b0;
            if (!span_end) begin
              k <= k + SPEED_W'(1);
            end else begin
              k    <= '0;
              prev <= cur_p0;
              if (clip_end) begin
                done <= 1'b1;
                addr <= rev ? i_end_addr : '0;
              end else begin
                addr <= addr_nx;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Stage p0: capture SRAM word once the read latency has elapsed
  // Stage p1: form the output sample for the current interpolation index
  always_ff @(posedge i_clk) begin
    if (state == S_FETCH && fetch_last)
      cur_p0 <= i_sram_data;
    if (state == S_CALC)
      samp_p1 <= (mode_sel == M_LIN) ? lin_interp(prev, cur_p0, k, spd_sel) : cur_p0;
  end

  assign o_sram_addr = addr;
  assign o_dac_data  = dac;
  assign o_player_en = en;
  assign o_done      = done;

endmodule

// File: tb/tb_aud_dsp_gen2.sv
// Randomized self-checking bench for aud_dsp_gen2 with a clip-level reference model
// that lists every sample the player should receive for a given mode, speed and direction.
module tb_aud_dsp_gen2;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 20;
  localparam int SPEED_W = 4;

  logic               clk, rst_n;
  logic               start, pause, stop, fast, slow0, slow1, rev;
  logic [SPEED_W-1:0] speed;
  logic [ADDR_W-1:0]  end_addr;
  logic               lrck;
  logic [DATA_W-1:0]  sram_data, rd1, rd2;
  logic [ADDR_W-1:0]  sram_addr;
  logic [DATA_W-1:0]  dac;
  logic               en, ack, done;

  logic [DATA_W-1:0]  mem [64];
  int                 exp_q[$];
  int                 n_chk, n_err, got_cnt, exp_total, ack_lat;
  bit                 mon_on, ack_on;

  aud_dsp_gen2 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SPEED_W(SPEED_W), .RD_LAT(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pause(pause), .i_stop(stop),
    .i_fast(fast), .i_slow_0(slow0), .i_slow_1(slow1), .i_reverse(rev),
    .i_speed(speed), .i_end_addr(end_addr), .i_daclrck(lrck),
    .i_sram_data(sram_data), .o_sram_addr(sram_addr), .o_dac_data(dac),
    .o_player_en(en), .i_player_ack(ack), .o_done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    lrck = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      lrck = ~lrck;
    end
  end

  // SRAM with a two-cycle read latency
  always @(posedge clk) begin
    rd1 <= mem[sram_addr[5:0]];
    rd2 <= rd1;
  end
  assign sram_data = rd2;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: every sample the player should receive for one clip
  function automatic void build_exp(input bit f, input bit s0, input bit s1, input bit r,
                                    input int spd, input int ea);
    int es, a, p, c;
    es = (spd == 0) ? 1 : spd;
    a  = r ? ea : 0;
    p  = 0;
    exp_q.delete();
    while (a >= 0 && a <= ea) begin
      c = int'($signed(mem[a]));
      if (f) begin
        exp_q.push_back(c);
        a += r ? -es : es;
      end else begin
        if (s1) begin
          for (int kk = 0; kk < es; kk++)
            exp_q.push_back(int'(16'(p + ((c - p) * kk) / es)));
          p = c;
        end else if (s0) begin
          repeat (es) exp_q.push_back(c);
        end else begin
          exp_q.push_back(c);
        end
        a += r ? -1 : 1;
      end
    end
  endfunction

  // Player model: acks after a latency, checks each sample and the handshake shape
  initial begin : player
    int cnt, lat;
    bit seen;
    logic [DATA_W-1:0] held;
    ack = 1'b0; seen = 1'b0; cnt = 0; lat = 1; held = '0;
    forever begin
      @(negedge clk);
      if (en) begin
        if (!seen) begin
          seen = 1'b1;
          cnt  = 0;
          held = dac;
          lat  = (ack_lat < 0) ? int'($urandom_range(1, 3)) : ack_lat;
          if (mon_on) begin
            if (exp_q.size() == 0) check_val("sample_count", got_cnt + 1, exp_total);
            else check_val("sample", longint'($signed(dac)), longint'(exp_q.pop_front()));
            got_cnt++;
          end
        end
        cnt++;
        if (ack_on && cnt >= lat) ack = 1'b1;
      end else begin
        if (seen && mon_on) begin
          check_val("en_held_to_ack", longint'(ack), 1);
          check_val("dac_hold", longint'(dac), longint'(held));
        end
        seen = 1'b0;
        ack  = 1'b0;
        cnt  = 0;
      end
    end
  end

  task automatic begin_clip(input bit f, input bit s0, input bit s1, input bit r,
                            input int spd, input int ea);
    build_exp(f, s0, s1, r, spd, ea);
    exp_total = exp_q.size();
    got_cnt   = 0;
    mon_on    = 1'b1;
    fast = f; slow0 = s0; slow1 = s1; rev = r;
    speed = SPEED_W'(spd); end_addr = ADDR_W'(ea);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic finish_clip(input string tag, input int ea);
    int n;
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_done_seen"}, longint'(done), 1);
    @(negedge clk);
    check_val({tag, "_done_width"}, longint'(done), 0);
    check_val({tag, "_count"}, got_cnt, exp_total);
    check_val({tag, "_rewind"}, longint'(sram_addr), rev ? ea : 0);
    check_val({tag, "_en_idle"}, longint'(en), 0);
    mon_on = 1'b0;
  endtask

  task automatic run_clip(input string tag, input bit f, input bit s0, input bit s1,
                          input bit r, input int spd, input int ea);
    begin_clip(f, s0, s1, r, spd, ea);
    finish_clip(tag, ea);
  endtask

  task automatic wait_en(input string tag);
    int n;
    n = 0;
    while (!en && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_en_rise"}, longint'(en), 1);
  endtask

  initial begin : main
    int n, en_hi;
    logic [ADDR_W-1:0] a_hold;
    n_chk = 0; n_err = 0; got_cnt = 0; exp_total = 0;
    ack_lat = 2; mon_on = 1'b0; ack_on = 1'b1;
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    fast = 1'b0; slow0 = 1'b0; slow1 = 1'b0; rev = 1'b0;
    speed = '0; end_addr = '0;
    for (int i = 0; i < 64; i++) mem[i] = 16'(16 * i);
    repeat (3) @(negedge clk);
    check_val("rst_addr", longint'(sram_addr), 0);
    check_val("rst_dac", longint'(dac), 0);
    check_val("rst_en", longint'(en), 0);
    check_val("rst_done", longint'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_clip("normal", 1'b0, 1'b0, 1'b0, 1'b0, 0, 3);

    ack_lat = -1;
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    run_clip("fast2", 1'b1, 1'b0, 1'b0, 1'b0, 2, 7);

    mem[0] = 16'(0); mem[1] = 16'(64); mem[2] = 16'(-64);
    run_clip("lin4", 1'b0, 1'b0, 1'b1, 1'b0, 4, 2);

    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    run_clip("s0s1_lin", 1'b0, 1'b1, 1'b1, 1'b0, 3, 3);
    run_clip("all_fast", 1'b1, 1'b1, 1'b1, 1'b0, 3, 6);

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
      run_clip("rand", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 15)), int'($urandom_range(1, 5)));
    end

    // pause mid-span at k=2 and resume
    mem[0] = 16'(0); mem[1] = 16'(64); mem[2] = 16'(-64);
    begin_clip(1'b0, 1'b0, 1'b1, 1'b0, 4, 2);
    n = 0;
    while (!(got_cnt >= 6 && !en) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    pause  = 1'b1;
    a_hold = sram_addr;
    en_hi  = 0;
    repeat (1000) begin
      @(negedge clk);
      if (en) en_hi++;
    end
    check_val("pause_en_quiet", en_hi, 0);
    check_val("pause_addr_kept", longint'(sram_addr), longint'(a_hold));
    pause = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    finish_clip("pause_resume", 2);

    // stop together with start: stays idle
    rev = 1'b0; end_addr = ADDR_W'(3);
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    en_hi = 0; n = 0;
    repeat (30) begin
      @(negedge clk);
      if (en) en_hi++;
      if (sram_addr != '0) n++;
    end
    check_val("stop_start_en", en_hi, 0);
    check_val("stop_start_addr", n, 0);

    // stop during an unacknowledged handshake
    ack_on = 1'b0;
    fast = 1'b0; slow0 = 1'b0; slow1 = 1'b0; end_addr = ADDR_W'(3);
    for (int i = 0; i < 64; i++) mem[i] = 16'(16 * i + 5);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_en("stop_play");
    repeat (3) @(negedge clk);
    check_val("unacked_en_held", longint'(en), 1);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check_val("stop_play_en", longint'(en), 0);
    check_val("stop_play_addr", longint'(sram_addr), 0);
    check_val("stop_play_dac", longint'(dac), 0);
    ack_on = 1'b1;

    run_clip("reverse", 1'b0, 1'b0, 1'b0, 1'b1, 1, 5);

    // asynchronous reset while a sample is pending
    ack_on = 1'b0;
    rev = 1'b0; end_addr = ADDR_W'(4);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_en("rst_play");
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_en", longint'(en), 0);
    check_val("async_rst_addr", longint'(sram_addr), 0);
    @(negedge clk); rst_n = 1'b1;
    ack_on = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/aud_dsp_gen2.md
AUD_DSP_GEN2 -- requirements
Module: aud_dsp_gen2

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- DATA_W, 16, signed sample width
- ADDR_W, 20, SRAM word-address width
- SPEED_W, 4, speed field width (factor 1..2^SPEED_W-1)
- RD_LAT, 2, cycles from o_sram_addr change to valid i_sram_data
REQ-002 SHALL have ports (name, direction, width, meaning):
- i_clk, in, 1, sole clock, rising edge
- i_rst_n, in, 1, asynchronous active-low reset
- i_start, in, 1, start / resume
- i_pause, in, 1, pause request
- i_stop, in, 1, stop and rewind
- i_fast, in, 1, fast mode select
- i_slow_0, in, 1, slow mode, zero-order hold
- i_slow_1, in, 1, slow mode, linear interpolation
- i_reverse, in, 1, play toward address 0
- i_speed, in, SPEED_W, speed factor
- i_end_addr, in, ADDR_W, last valid sample address
- i_daclrck, in, 1, DAC LR clock
- i_sram_data, in, DATA_W, read data
- o_sram_addr, out, ADDR_W, read address
- o_dac_data, out, DATA_W, sample to player
- o_player_en, out, 1, sample valid
- i_player_ack, in, 1, player accepted sample
- o_done, out, 1, one-cycle end-of-clip pulse

Function
REQ-003 SHALL implement states IDLE, FETCH, CALC, WAIT_LRCK, PLAY and PAUSED.
- IDLE->FETCH on i_start.
- FETCH holds o_sram_addr for RD_LAT cycles, then captures i_sram_data ->CALC.
- CALC->WAIT_LRCK.
- WAIT_LRCK->PLAY on i_daclrck falling edge, detected with a registered copy of i_daclrck.
- PLAY->FETCH (or CALC when no new fetch is needed) after ack.
REQ-004 Player handshake SHALL work as follows:
- o_player_en rises on entry to PLAY, with o_dac_data valid.
- o_player_en stays high until i_player_ack is sampled high, then falls on the next cycle.
- o_dac_data SHALL hold until the next PLAY entry.
REQ-005 Mode priority SHALL be i_fast > i_slow_1 > i_slow_0 > normal (1x); an i_speed of 0 SHALL be treated as 1.
REQ-006 Mode and i_speed SHALL be sampled only at stored-sample boundaries (interpolation index k=0); mid-span changes take effect at the next boundary.
REQ-007 Fast mode: one output per stored sample; the address steps by speed.
REQ-008 Slow mode (ZOH): each stored sample is output speed times.
REQ-009 Slow mode (linear): outputs prev+((cur-prev)*k)/speed for k=0..speed-1.
- Arithmetic uses DATA_W+SPEED_W+1-bit signed values.
- Division truncates toward zero; the result is truncated to DATA_W.
- After k=speed-1, prev<=cur and the next sample is fetched.
REQ-010 Address direction: forward adds the step; reverse (i_reverse, sampled at start from IDLE only) subtracts the step.
REQ-011 End of clip: if the next address would exceed i_end_addr (forward) or go below 0 (reverse), the block SHALL:
- complete the current handshake;
- pulse o_done for 1 cycle;
- enter IDLE with the address rewound to 0 (forward) or i_end_addr (reverse).
REQ-012 Command priority SHALL be i_stop > i_pause > i_start on simultaneous assertion.
REQ-013 i_stop SHALL act in any state on the next edge:
- IDLE;
- address rewound;
- o_player_en=0, o_dac_data=0;
- prev=0, k=0.
REQ-014 i_pause SHALL take effect at the next WAIT_LRCK entry, or immediately if not in PLAY.
- PAUSED retains address, prev and k.
- i_start resumes at FETCH.
- An in-progress handshake always completes.
REQ-015 Starting from IDLE SHALL clear prev to 0 and k to 0.

Reset
REQ-016 While i_rst_n=0, the following SHALL apply:
- state IDLE;
- o_sram_addr=0, o_dac_data=0, o_player_en=0, o_done=0;
- prev=0, k=0, direction forward.
REQ-017 Reset assertion mid-PLAY SHALL drop o_player_en asynchronously without waiting for ack.

Verification
REQ-018 Normal, SRAM[i]=16*i, end=3, ack 2 cycles after en: o_dac_data 0,16,32,48, then o_done pulse, IDLE, addr=0.
REQ-019 Fast, speed=2, end=7: outputs from addrs 0,2,4,6; o_done after 4 samples.
REQ-020 Slow_1, speed=4, SRAM[0]=0, SRAM[1]=64, SRAM[2]=-64: outputs 0,0,0,0, then 0,16,32,48, then 64,32,0,-32.
REQ-021 Slow_0 and slow_1 both high, speed=3: linear interpolation output (slow_1 wins); with i_fast also high: fast.
REQ-022 Pause held 1000 cycles mid-interpolation (k=2), then start: resumes at k=2 with identical data; o_player_en never glitches.
REQ-023 Stop asserted with start, and stop during an unacked PLAY: IDLE next cycle, o_player_en=0, addr=0; reverse start, end=5: addrs 5,4,...,0, then o_done.
